lsu_ctrl: RTL

Load/store control unit between the MEM pipeline stage and the word-wide data memory (`DM`). Accepts byte/halfword/word load and store requests on byte addresses through a valid/ready handshake. Detects misalignment, sequences word loads and read-modify-write sub-word stores against DM over multiple cycles, and returns extracted, sign- or zero-extended load data with a one-cycle response pulse. Memory byte order is big-endian.

---
 rtl/lsu_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control between the MEM stage and a word-wide,
// big-endian data memory (DM). Accepts byte/half/word loads and stores,
// flags misaligned requests without touching DM, performs word loads
// with lane extraction and sign/zero extension, and performs sub-word
// stores as a read-modify-write of the containing word.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake; accept on valid & ready edge
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 treated as word
//   req_signed        load extension select (ignored for word loads)
//   req_addr          byte address
//   req_wdata         right-justified store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load result (0 for stores and faults), held
//   resp_misaligned   fault flag, held with resp_rdata
//   dm_addr           DM word index (latched byte address >> 2)
//   dm_wdata          merged write word, 0 outside WRITE
//   dm_write/dm_read  DM strobes, mutually exclusive
//   dm_rdata          DM combinational read data
//
// state  | meaning
// IDLE   | ready for a request; latch fields on accept
// LOAD   | read DM word, capture extracted/extended result
// RMW_RD | read DM word into merge buffer for a sub-word store
// WRITE  | write merged word (or full store word) to DM
// RESP   | response pulse, then back to IDLE
module lsu_ctrl #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [WORD_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic [WORD_WIDTH-1:0] dm_addr,
    output logic [WORD_WIDTH-1:0] dm_wdata,
    output logic                  dm_write,
    output logic                  dm_read,
    input  logic [WORD_WIDTH-1:0] dm_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [1:0]            size_q;
    logic                  sgn_q;
    logic [WORD_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [WORD_WIDTH-1:0] merge_q;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  mis_q;

    logic                  accept;
    logic                  req_mis;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [WORD_WIDTH-1:0] load_ext;
    logic [WORD_WIDTH-1:0] merged;

    assign accept = req_valid && (state == S_IDLE);

    // Size 11 is handled as a word everywhere, so size[1] means "word".
    always_comb begin
        req_mis = 1'b0;
        if (req_size == 2'b01)
            req_mis = req_addr[0];
        else if (req_size[1])
            req_mis = |req_addr[1:0];
    end

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        lane_b = 8'h00;
        case (addr_q[1:0])
            2'd0: lane_b = dm_rdata[31:24];
            2'd1: lane_b = dm_rdata[23:16];
            2'd2: lane_b = dm_rdata[15:8];
            default: lane_b = dm_rdata[7:0];
        endcase
        lane_h = addr_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        case (size_q)
            2'b00: load_ext = sgn_q ? {{(WORD_WIDTH-8){lane_b[7]}}, lane_b}
                                    : {{(WORD_WIDTH-8){1'b0}}, lane_b};
            2'b01: load_ext = sgn_q ? {{(WORD_WIDTH-16){lane_h[15]}}, lane_h}
                                    : {{(WORD_WIDTH-16){1'b0}}, lane_h};
            default: load_ext = dm_rdata;
        endcase
    end

    always_comb begin
        merged = merge_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merged[31:24] = wdata_q[7:0];
                    2'd1: merged[23:16] = wdata_q[7:0];
                    2'd2: merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1])
                    merged[15:0] = wdata_q[15:0];
                else
                    merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        dm_read = 1'b0;
        dm_write = 1'b0;
        dm_wdata = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_mis)
                        state_nxt = S_RESP;
                    else if (!req_write)
                        state_nxt = S_LOAD;
                    else if (req_size[1])
                        state_nxt = S_WRITE;
                    else
                        state_nxt = S_RMW_RD;
                end
            end
            S_LOAD: begin
                dm_read = 1'b1;
                state_nxt = S_RESP;
            end
            S_RMW_RD: begin
                dm_read = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                dm_write = 1'b1;
                dm_wdata = merged;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result and fault flag only change on the edge that enters RESP, so
    // they hold the previous response throughout the next operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q  <= '0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (accept) begin
                size_q  <= req_size;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (req_mis) begin
                    rdata_q <= '0;
                    mis_q   <= 1'b1;
                end
            end
            if (state == S_LOAD) begin
                rdata_q <= load_ext;
                mis_q   <= 1'b0;
            end
            if (state == S_RMW_RD)
                merge_q <= dm_rdata;
            if (state == S_WRITE) begin
                rdata_q <= '0;
                mis_q   <= 1'b0;
            end
        end
    end

    assign dm_addr         = {2'b00, addr_q[WORD_WIDTH-1:2]};
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;

endmodule
